// File: rtl/mips_lsu_pkg.sv
// Shared types and constants for the MIPS load/store unit.
package mips_lsu_pkg;

  // Access size encoding as driven by the datapath; 2'b11 is illegal.
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mips_lsu_lane.sv
// Byte-lane logic: alignment check, store lane steering and load extraction.
// Purely combinational; the request side looks at the live CPU request, the
// read side at the access parameters captured when the request was issued.
module mips_lsu_lane
  import mips_lsu_pkg::*;
(
  input  logic [1:0]  req_size_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  rd_off_i,
  input  logic        rd_signed_i,
  input  logic [31:0] rd_word_i,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Alignment check plus byte-enable mask and lane-replicated store data.
  always_comb begin
    misalign_o = 1'b0;
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    case (req_size_i)
      SZ_B: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_H: begin
        misalign_o = req_off_i[0];
        be_o       = req_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{req_wdata_i[15:0]}};
      end
      SZ_W: begin
        misalign_o = |req_off_i;
        be_o       = 4'b1111;
        wdata_o    = req_wdata_i;
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 and zero/sign-extend it.
  always_comb begin
    shifted = rd_word_i >> {rd_off_i, 3'b000};
    rdata_o = shifted;
    case (rd_size_i)
      SZ_B:    rdata_o = {{24{rd_signed_i & shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_o = {{16{rd_signed_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;   // aligned word: offset is zero
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: turns one CPU byte/half/word access into a word-wide
// req/ack memory transaction, stalling the core until it completes, is
// rejected as misaligned, or times out.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for cpu_req; only state that accepts a request
//   ACCESS | mem_req held with stable fields until ack or timeout
//   RESP   | done/err pulse visible to the core; back to IDLE next
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [1:0]  cpu_errcode,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Timeout timer counts down from TIMEOUT_CYC-1; terminal count is zero.
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  errcode_q, errcode_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [1:0]  rd_size_q, rd_size_d;
  logic [1:0]  rd_off_q, rd_off_d;
  logic        rd_signed_q, rd_signed_d;

  logic        lane_misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  mips_lsu_lane u_lane (
    .req_size_i  (cpu_size),
    .req_off_i   (cpu_addr[1:0]),
    .req_wdata_i (cpu_wdata),
    .rd_size_i   (rd_size_q),
    .rd_off_i    (rd_off_q),
    .rd_signed_i (rd_signed_q),
    .rd_word_i   (mem_rdata),
    .misalign_o  (lane_misalign),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata)
  );

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    errcode_d   = errcode_q;
    rdata_d     = rdata_q;
    tmr_d       = tmr_q;
    rd_size_d   = rd_size_q;
    rd_off_d    = rd_off_q;
    rd_signed_d = rd_signed_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (lane_misalign) begin
            err_d     = 1'b1;
            errcode_d = ERR_MISALIGN;
            rdata_d   = 32'h0;
            state_d   = ST_RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = cpu_we;
            mem_addr_d  = {cpu_addr[31:2], 2'b00};
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
            tmr_d       = TMR_LOAD;
            rd_size_d   = cpu_size;
            rd_off_d    = cpu_addr[1:0];
            rd_signed_d = cpu_signed;
            state_d     = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        // An ack on the terminal-count cycle still wins over the timeout.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!mem_we_q) begin
            rdata_d = lane_rdata;
          end
          state_d = ST_RESP;
        end else if (tmr_q == '0) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          errcode_d = ERR_TIMEOUT;
          rdata_d   = 32'h0;
          state_d   = ST_RESP;
        end else begin
          tmr_d = tmr_q - CW'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      errcode_q   <= 2'b00;
      rdata_q     <= 32'h0;
      tmr_q       <= '0;
      rd_size_q   <= 2'b00;
      rd_off_q    <= 2'b00;
      rd_signed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      errcode_q   <= errcode_d;
      rdata_q     <= rdata_d;
      tmr_q       <= tmr_d;
      rd_size_q   <= rd_size_d;
      rd_off_q    <= rd_off_d;
      rd_signed_q <= rd_signed_d;
    end
  end

  assign cpu_stall   = cpu_req & ~done_q & ~err_q;
  assign cpu_done    = done_q;
  assign cpu_err     = err_q;
  assign cpu_errcode = errcode_q;
  assign cpu_rdata   = rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: directed cases with literal expectations plus random
// accesses, all checked every cycle against a transaction-timing model.
module tb_mips_lsu;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_signed;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [1:0]  cpu_errcode;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mips_lsu #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_errcode(cpu_errcode), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem_m [0:31];

  // Current transaction, described by its parameters only.
  bit          t_active = 1'b0;
  bit          t_mis, t_ack, t_we;
  int          t_start, t_nwait, t_end, t_rst;
  logic [31:0] t_addrw, t_wdata, t_rdata;
  logic [3:0]  t_be;

  // Observations used by the literal checks.
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_be;
  logic [1:0]  cap_errcode;
  int done_cyc, err_cyc, rise_cyc, fall_cyc;
  int done_cnt = 0, err_cnt = 0, rise_cnt = 0;
  bit prev_mreq = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = (nbytes(sz) == 4) ? 0 : int'(a[1:0]);
    return 4'(((1 << nbytes(sz)) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wrep(input logic [1:0] sz, input logic [31:0] wd);
    if (nbytes(sz) == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (nbytes(sz) == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ext(input logic [1:0] sz, input logic [31:0] a,
                                        input bit sgn, input logic [31:0] w);
    int n;
    logic [31:0] mask, v;
    n = nbytes(sz);
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> (8 * int'(a[1:0]))) & mask;
    if (sgn && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // Per-cycle compare of DUT outputs against the transaction model.
  always @(negedge clk) begin
    int k;
    bit in_rst, e_mreq, e_done, e_err;
    if (chk_en) begin
      if (t_active) begin
        k      = cyc - t_start;
        in_rst = (t_rst >= 0) && (k > t_rst);
        e_mreq = !t_mis && !in_rst && k >= 1 && k <= (t_ack ? 1 + t_nwait : T);
        e_done = !in_rst && t_ack && k == 2 + t_nwait;
        e_err  = !in_rst && !t_ack && (t_rst < 0) && k == t_end;
        chk("mem_req", 32'(mem_req), 32'(e_mreq));
        chk("cpu_done", 32'(cpu_done), 32'(e_done));
        chk("cpu_err", 32'(cpu_err), 32'(e_err));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_done & ~e_err));
        if (e_err) begin
          chk("errcode", 32'(cpu_errcode), t_mis ? 32'h1 : 32'h2);
          if (!t_mis) chk("tmo_rdata", cpu_rdata, 32'h0);
        end
        if (e_done && !t_we) chk("rdata", cpu_rdata, t_rdata);
        if (e_mreq) begin
          chk("mem_we", 32'(mem_we), 32'(t_we));
          chk("mem_addr", mem_addr, t_addrw);
          chk("mem_be", 32'(mem_be), 32'(t_be));
          if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
        end
        if (in_rst) begin
          chk("rst_mem_we", 32'(mem_we), 32'h0);
          chk("rst_mem_addr", mem_addr, 32'h0);
          chk("rst_mem_be", 32'(mem_be), 32'h0);
          chk("rst_mem_wdata", mem_wdata, 32'h0);
          chk("rst_errcode", 32'(cpu_errcode), 32'h0);
          chk("rst_rdata", cpu_rdata, 32'h0);
        end
      end else begin
        chk("idle_mem_req", 32'(mem_req), 32'h0);
        chk("idle_done", 32'(cpu_done), 32'h0);
        chk("idle_err", 32'(cpu_err), 32'h0);
      end
      if (mem_req) begin
        cap_addr  = mem_addr;
        cap_be    = mem_be;
        cap_wdata = mem_wdata;
      end
      if (cpu_done) begin
        cap_rdata = cpu_rdata;
        done_cyc  = cyc;
        done_cnt++;
      end
      if (cpu_err) begin
        cap_errcode = cpu_errcode;
        err_cyc     = cyc;
        err_cnt++;
      end
      if (mem_req && !prev_mreq) begin
        rise_cyc = cyc;
        rise_cnt++;
      end
      if (!mem_req && prev_mreq) fall_cyc = cyc;
      prev_mreq = mem_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU access. nwait<0 or >=T: memory never acks. rstk>=0: reset is
  // pulled low in that cycle of the access.
  task automatic do_access(input bit we, input logic [1:0] sz, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int nwait, input bit drop, input int rstk);
    int idx;
    idx       = int'(addr[6:2]);
    t_start   = cyc;
    t_we      = we;
    t_mis     = m_mis(sz, addr);
    t_nwait   = nwait;
    t_rst     = rstk;
    t_ack     = !t_mis && nwait >= 0 && nwait < T && rstk < 0;
    t_end     = (rstk >= 0) ? rstk + 1 : t_mis ? 1 : t_ack ? 2 + nwait : T + 1;
    t_addrw   = {addr[31:2], 2'b00};
    t_be      = m_be(sz, addr);
    t_wdata   = m_wrep(sz, wd);
    t_rdata   = m_ext(sz, addr, sgn, mem_m[idx]);
    t_active  = 1'b1;
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_size   = sz;
    cpu_signed = sgn;
    cpu_addr   = addr;
    cpu_wdata  = wd;
    mem_ack    = 1'b0;
    for (int k = 1; k <= t_end; k++) begin
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (drop && k == 1) cpu_req = 1'b0;
      if (t_ack && k == 1 + nwait) begin
        mem_ack = 1'b1;
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (t_be[b]) mem_m[idx][8*b +: 8] = t_wdata[8*b +: 8];
        end else begin
          mem_rdata = mem_m[idx];
        end
      end
      if (rstk >= 0 && k == rstk) reset_n = 1'b0;
      if (rstk >= 0 && k == rstk + 1) begin
        reset_n = 1'b1;
        cpu_req = 1'b0;
      end
    end
    step();
    cpu_req  = 1'b0;
    mem_ack  = 1'b0;
    t_active = 1'b0;
  endtask

  task automatic idle(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      step();
      mem_ack   = spurious ? 1'($urandom % 2) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  initial begin
    int s, r0, e0, d0, nw;
    bit we, sg, dr;
    logic [1:0] sz;

    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_signed = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 32; i++) mem_m[i] = $urandom;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_done", 32'(cpu_done), 32'h0);
    chk("rst_err", 32'(cpu_err), 32'h0);
    chk("rst_errcode", 32'(cpu_errcode), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    idle(1, 1'b0);

    // sb 0xA5 to 0x13, zero-wait
    do_access(1'b1, 2'b00, 1'b0, 32'h13, 32'hA5, 0, 1'b0, -1);
    chk("t1_addr", cap_addr, 32'h10);
    chk("t1_be", 32'(cap_be), 32'h8);
    chk("t1_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("t1_done_cyc", 32'(done_cyc - t_start), 32'd2);
    idle(1, 1'b0);

    // sub-word loads, 3 wait states
    mem_m[0] = 32'h80F07F11;
    do_access(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 3, 1'b0, -1);
    chk("t2_lh", cap_rdata, 32'hFFFF80F0);
    chk("t2_lh_cyc", 32'(done_cyc - t_start), 32'd5);
    do_access(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 3, 1'b0, -1);
    chk("t2_lhu", cap_rdata, 32'h000080F0);
    do_access(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, 3, 1'b0, -1);
    chk("t2_lb", cap_rdata, 32'h0000007F);

    // misaligned: lw 0x6, sh 0x1, size 11
    r0 = rise_cnt;
    do_access(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, 1'b0, -1);
    chk("t3_lw_cyc", 32'(err_cyc - t_start), 32'd1);
    chk("t3_lw_code", 32'(cap_errcode), 32'h1);
    do_access(1'b1, 2'b01, 1'b0, 32'h1, 32'h1234, 0, 1'b0, -1);
    chk("t3_sh_code", 32'(cap_errcode), 32'h1);
    do_access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, 1'b0, -1);
    chk("t3_sz3_code", 32'(cap_errcode), 32'h1);
    chk("t3_no_mem_req", 32'(rise_cnt - r0), 32'd0);

    // timeout, then a late ack at cycle 7
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, -1, 1'b0, -1);
    s = t_start;
    chk("t4_err_cyc", 32'(err_cyc - s), 32'd5);
    chk("t4_code", 32'(cap_errcode), 32'h2);
    chk("t4_req_len", 32'(fall_cyc - rise_cyc), 32'd4);
    e0 = err_cnt; d0 = done_cnt;
    step();
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    idle(2, 1'b0);
    chk("t4_late_ack_err", 32'(err_cnt - e0), 32'd0);
    chk("t4_late_ack_done", 32'(done_cnt - d0), 32'd0);

    // reset asserted in cycle 2 of a waiting sw
    e0 = err_cnt; d0 = done_cnt;
    do_access(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF, -1, 1'b0, 2);
    idle(2, 1'b0);
    chk("t5_no_err", 32'(err_cnt - e0), 32'd0);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // back-to-back sw / lw at 0x40: RESP cycle, then one IDLE cycle
    do_access(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 1, 1'b0, -1);
    d0 = done_cyc;
    do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2, 1'b0, -1);
    chk("t6_rdata", cap_rdata, 32'h12345678);
    chk("t6_idle_gap", 32'(rise_cyc - d0), 32'd2);

    // random accesses
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom % 2);
      sg = 1'($urandom % 2);
      sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      case ($urandom % 8)
        0:       nw = -1;
        1:       nw = T;
        default: nw = int'($urandom % T);
      endcase
      dr = ($urandom % 4 == 0);
      do_access(we, sz, sg, 32'($urandom_range(0, 127)), $urandom, nw, dr, -1);
      idle(int'($urandom % 3), 1'b1);
      mem_ack = 1'b0;
    end
    idle(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
